riscv_ahb3lite_arbiter: RTL

- N-master to 1-slave AHB3-Lite arbiter/mux.
- Merges the core's instruction and data AHB3-Lite master ports, plus optional extra masters (e.g. a debug DMA), onto a single shared AHB3-Lite master port.
- Generalised in master count, bus width and arbitration mode.
- Supports locked transfers and burst retention.
- A master that is not granted has its address phase latched and replayed later, so it never has to re-issue it.

---
 rtl/riscv_ahb3lite_arbiter_if.sv | 55 +++++
 rtl/riscv_ahb3lite_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_ahb3lite_arbiter_if.sv
// Bundle of AHB3-Lite signals around the N:1 arbiter: upstream master
// ports (mst_*) and the shared downstream slave-facing bus (slv_*).
// 'slave' is the arbiter's view, since it is the slave of the masters.
// 'master' is the environment's view: the masters plus the downstream slave.
interface riscv_ahb3lite_arbiter_if #(
   parameter int MASTERS    = 2,
   parameter int HADDR_SIZE = 32,
   parameter int HDATA_SIZE = 32
);
   // upstream masters
   logic [MASTERS-1:0]                 mst_HSEL;
   logic [MASTERS-1:0][HADDR_SIZE-1:0] mst_HADDR;
   logic [MASTERS-1:0][HDATA_SIZE-1:0] mst_HWDATA;
   logic [MASTERS-1:0]                 mst_HWRITE;
   logic [MASTERS-1:0][2:0]            mst_HSIZE;
   logic [MASTERS-1:0][2:0]            mst_HBURST;
   logic [MASTERS-1:0][3:0]            mst_HPROT;
   logic [MASTERS-1:0][1:0]            mst_HTRANS;
   logic [MASTERS-1:0]                 mst_HMASTLOCK;
   logic [HDATA_SIZE-1:0]              mst_HRDATA;
   logic [MASTERS-1:0]                 mst_HREADYOUT;
   logic [MASTERS-1:0]                 mst_HRESP;

   // shared downstream bus
   logic                               slv_HSEL;
   logic [HADDR_SIZE-1:0]              slv_HADDR;
   logic [HDATA_SIZE-1:0]              slv_HWDATA;
   logic                               slv_HWRITE;
   logic [2:0]                         slv_HSIZE;
   logic [2:0]                         slv_HBURST;
   logic [3:0]                         slv_HPROT;
   logic [1:0]                         slv_HTRANS;
   logic                               slv_HMASTLOCK;
   logic [HDATA_SIZE-1:0]              slv_HRDATA;
   logic                               slv_HREADY;
   logic                               slv_HRESP;

   modport slave (
      input  mst_HSEL, mst_HADDR, mst_HWDATA, mst_HWRITE, mst_HSIZE,
             mst_HBURST, mst_HPROT, mst_HTRANS, mst_HMASTLOCK,
      output mst_HRDATA, mst_HREADYOUT, mst_HRESP,
      output slv_HSEL, slv_HADDR, slv_HWDATA, slv_HWRITE, slv_HSIZE,
             slv_HBURST, slv_HPROT, slv_HTRANS, slv_HMASTLOCK,
      input  slv_HRDATA, slv_HREADY, slv_HRESP
   );

   modport master (
      output mst_HSEL, mst_HADDR, mst_HWDATA, mst_HWRITE, mst_HSIZE,
             mst_HBURST, mst_HPROT, mst_HTRANS, mst_HMASTLOCK,
      input  mst_HRDATA, mst_HREADYOUT, mst_HRESP,
      input  slv_HSEL, slv_HADDR, slv_HWDATA, slv_HWRITE, slv_HSIZE,
             slv_HBURST, slv_HPROT, slv_HTRANS, slv_HMASTLOCK,
      output slv_HRDATA, slv_HREADY, slv_HRESP
   );
endinterface

// File: rtl/riscv_ahb3lite_arbiter.sv
// N-master to 1-slave AHB3-Lite arbiter/mux.
// The address-phase winner is picked combinationally in every ready cycle,
// so a granted master reaches the slave with no added latency. A master that
// issued an address phase while it was not granted has that phase latched
// and replayed later; it is stalled via HREADYOUT until the replayed
// transfer's data phase completes. Bursts (SEQ/BUSY) and locked sequences
// keep the current owner.
module riscv_ahb3lite_arbiter #(
   parameter int MASTERS    = 2,
   parameter int HADDR_SIZE = 32,
   parameter int HDATA_SIZE = 32,
   parameter int ARB_MODE   = 0
) (
   input  logic                       HCLK,
   input  logic                       HRESET,
   riscv_ahb3lite_arbiter_if.slave    bus,
   output logic [$clog2(MASTERS)-1:0] owner
);
   localparam int MW = $clog2(MASTERS);

   localparam logic [1:0] HTRANS_IDLE = 2'b00;
   localparam logic [1:0] HTRANS_BUSY = 2'b01;
   localparam logic [1:0] HTRANS_SEQ  = 2'b11;

   typedef logic [MW-1:0] mid_t;

   // arbitration / data-phase state
   mid_t owner_q, owner_d;
   mid_t last_grant_q, last_grant_d;
   mid_t dp_owner_q, dp_owner_d;
   logic dp_valid_q, dp_valid_d;
   logic dp_lock_q, dp_lock_d;

   // latched address phases waiting for replay
   logic [MASTERS-1:0]                 pend_valid_q, pend_valid_d;
   logic [MASTERS-1:0][HADDR_SIZE-1:0] pend_addr_q, pend_addr_d;
   logic [MASTERS-1:0]                 pend_write_q, pend_write_d;
   logic [MASTERS-1:0][2:0]            pend_size_q, pend_size_d;
   logic [MASTERS-1:0][2:0]            pend_burst_q, pend_burst_d;
   logic [MASTERS-1:0][3:0]            pend_prot_q, pend_prot_d;
   logic [MASTERS-1:0][1:0]            pend_trans_q, pend_trans_d;
   logic [MASTERS-1:0]                 pend_lock_q, pend_lock_d;

   // effective address phase per master (replay copy or live signals)
   logic [MASTERS-1:0]                 cur_sel;
   logic [MASTERS-1:0][HADDR_SIZE-1:0] cur_addr;
   logic [MASTERS-1:0]                 cur_write;
   logic [MASTERS-1:0][2:0]            cur_size;
   logic [MASTERS-1:0][2:0]            cur_burst;
   logic [MASTERS-1:0][3:0]            cur_prot;
   logic [MASTERS-1:0][1:0]            cur_trans;
   logic [MASTERS-1:0]                 cur_lock;
   logic [MASTERS-1:0]                 cur_req;

   logic                               hold;
   logic                               arb_en;
   logic                               found;
   mid_t                               winner;
   mid_t                               grant;
   int                                 idx;

   logic [MASTERS-1:0]                 hready_out;
   logic [MASTERS-1:0]                 hresp_out;

   // select the replay copy while a master has a pending phase, else live
   always_comb begin
      for (int i = 0; i < MASTERS; i++) begin
         if (pend_valid_q[i]) begin
            cur_sel[i]   = 1'b1;
            cur_addr[i]  = pend_addr_q[i];
            cur_write[i] = pend_write_q[i];
            cur_size[i]  = pend_size_q[i];
            cur_burst[i] = pend_burst_q[i];
            cur_prot[i]  = pend_prot_q[i];
            cur_trans[i] = pend_trans_q[i];
            cur_lock[i]  = pend_lock_q[i];
         end else begin
            cur_sel[i]   = bus.mst_HSEL[i];
            cur_addr[i]  = bus.mst_HADDR[i];
            cur_write[i] = bus.mst_HWRITE[i];
            cur_size[i]  = bus.mst_HSIZE[i];
            cur_burst[i] = bus.mst_HBURST[i];
            cur_prot[i]  = bus.mst_HPROT[i];
            cur_trans[i] = bus.mst_HTRANS[i];
            cur_lock[i]  = bus.mst_HMASTLOCK[i];
         end
         cur_req[i] = cur_sel[i] & cur_trans[i][1];
      end
   end

   // pick the address-phase owner for this cycle
   always_comb begin
      // owner keeps the bus mid-burst, while locking, and while its last
      // locked transfer is still in its data phase
      hold = (cur_sel[owner_q] & ((cur_trans[owner_q] == HTRANS_SEQ) |
                                  (cur_trans[owner_q] == HTRANS_BUSY)))
           | cur_lock[owner_q]
           | dp_lock_q;
      arb_en = bus.slv_HREADY & ~hold;
      found  = 1'b0;
      winner = owner_q;
      idx    = 0;
      if (ARB_MODE == 0) begin
         // descending scan leaves the lowest requesting index
         for (int i = MASTERS - 1; i >= 0; i--) begin
            if (cur_req[i]) begin
               winner = mid_t'(i);
               found  = 1'b1;
            end
         end
      end else begin
         // descending scan leaves the first requester after last_grant
         for (int k = MASTERS; k >= 1; k--) begin
            idx = (int'(last_grant_q) + k) % MASTERS;
            if (cur_req[idx]) begin
               winner = mid_t'(idx);
               found  = 1'b1;
            end
         end
      end
      grant = arb_en ? winner : owner_q;
   end

   // ready/response steering: only the data-phase owner sees the slave
   always_comb begin
      hready_out = ~pend_valid_q;
      hresp_out  = '0;
      if (dp_valid_q) begin
         hready_out[dp_owner_q] = bus.slv_HREADY;
         hresp_out[dp_owner_q]  = bus.slv_HRESP;
      end
   end

   // next-state: pending latch/replay, owner and data-phase tracking
   always_comb begin
      pend_valid_d = pend_valid_q;
      pend_addr_d  = pend_addr_q;
      pend_write_d = pend_write_q;
      pend_size_d  = pend_size_q;
      pend_burst_d = pend_burst_q;
      pend_prot_d  = pend_prot_q;
      pend_trans_d = pend_trans_q;
      pend_lock_d  = pend_lock_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      dp_owner_d   = dp_owner_q;
      dp_valid_d   = dp_valid_q;
      dp_lock_d    = dp_lock_q;

      for (int i = 0; i < MASTERS; i++) begin
         if (pend_valid_q[i]) begin
            // replayed phase accepted by the slave
            if ((mid_t'(i) == grant) && bus.slv_HREADY)
               pend_valid_d[i] = 1'b0;
         end else if (bus.mst_HSEL[i] && bus.mst_HTRANS[i][1] && hready_out[i] &&
                      !((mid_t'(i) == grant) && bus.slv_HREADY)) begin
            // master believes its phase went out but the slave did not take it
            pend_valid_d[i] = 1'b1;
            pend_addr_d[i]  = bus.mst_HADDR[i];
            pend_write_d[i] = bus.mst_HWRITE[i];
            pend_size_d[i]  = bus.mst_HSIZE[i];
            pend_burst_d[i] = bus.mst_HBURST[i];
            pend_prot_d[i]  = bus.mst_HPROT[i];
            pend_trans_d[i] = bus.mst_HTRANS[i];
            pend_lock_d[i]  = bus.mst_HMASTLOCK[i];
         end
      end

      if (bus.slv_HREADY) begin
         owner_d    = grant;
         dp_owner_d = grant;
         dp_valid_d = cur_sel[grant] & cur_trans[grant][1];
         dp_lock_d  = cur_lock[grant];
         if (arb_en && found)
            last_grant_d = winner;
      end
   end

   // state registers; reset discards any pending phases
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         owner_q      <= '0;
         last_grant_q <= mid_t'(MASTERS - 1);
         dp_owner_q   <= '0;
         dp_valid_q   <= 1'b0;
         dp_lock_q    <= 1'b0;
         pend_valid_q <= '0;
         pend_addr_q  <= '0;
         pend_write_q <= '0;
         pend_size_q  <= '0;
         pend_burst_q <= '0;
         pend_prot_q  <= '0;
         pend_trans_q <= '0;
         pend_lock_q  <= '0;
      end else begin
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         dp_owner_q   <= dp_owner_d;
         dp_valid_q   <= dp_valid_d;
         dp_lock_q    <= dp_lock_d;
         pend_valid_q <= pend_valid_d;
         pend_addr_q  <= pend_addr_d;
         pend_write_q <= pend_write_d;
         pend_size_q  <= pend_size_d;
         pend_burst_q <= pend_burst_d;
         pend_prot_q  <= pend_prot_d;
         pend_trans_q <= pend_trans_d;
         pend_lock_q  <= pend_lock_d;
      end
   end

   assign bus.slv_HSEL      = cur_sel[grant];
   assign bus.slv_HADDR     = cur_addr[grant];
   assign bus.slv_HWRITE    = cur_write[grant];
   assign bus.slv_HSIZE     = cur_size[grant];
   assign bus.slv_HBURST    = cur_burst[grant];
   assign bus.slv_HPROT     = cur_prot[grant];
   assign bus.slv_HTRANS    = cur_sel[grant] ? cur_trans[grant] : HTRANS_IDLE;
   assign bus.slv_HMASTLOCK = cur_lock[grant];
   assign bus.slv_HWDATA    = bus.mst_HWDATA[dp_owner_q];

   assign bus.mst_HRDATA    = bus.slv_HRDATA;
   assign bus.mst_HREADYOUT = hready_out;
   assign bus.mst_HRESP     = hresp_out;

   assign owner             = owner_q;
endmodule
